// File: rtl/sum_cla_pkg.sv
// Shared constants and helpers for the pipelined carry-look-ahead adder.
package sum_cla_pkg;

    localparam int unsigned GRP_W = 4;

    function automatic bit width_ok(input int unsigned w);
        return (w >= 4) && (w <= 64) && ((w % GRP_W) == 0);
    endfunction

    // Returns {group generate, group propagate} of a 4-bit slice.
    function automatic logic [1:0] grp_gp(input logic [GRP_W-1:0] x, input logic [GRP_W-1:0] y);
        logic [GRP_W-1:0] g;
        logic [GRP_W-1:0] p;
        logic             gg;
        g  = x & y;
        p  = x ^ y;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-look-ahead slice: sum for a given carry-in plus group generate/propagate.
module cla_group
    import sum_cla_pkg::*;
(
    input  logic [GRP_W-1:0] i_a,
    input  logic [GRP_W-1:0] i_b,
    input  logic             i_c,
    output logic [GRP_W-1:0] o_s,
    output logic             o_g,
    output logic             o_p
);

    logic [GRP_W-1:0] w_g;
    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s        = w_p ^ w_c;
    assign {o_g, o_p} = grp_gp(i_a, i_b);

endmodule

// File: rtl/sum_cla_pipe.sv
// Two-stage pipelined adder/subtractor: stage 1 registers group g/p, stage 2 resolves
// group carries with a second-level look-ahead and registers the result.
module sum_cla_pipe
    import sum_cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             G,
    output logic             P
);

    localparam int unsigned NGRP = WIDTH / GRP_W;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("sum_cla_pipe: WIDTH must be a multiple of 4 in 4..64");
    end

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [NGRP-1:0]  w_gg1;
    logic [NGRP-1:0]  w_gp1;

    logic             r_s1_valid;
    logic [NGRP-1:0]  r_gg;
    logic [NGRP-1:0]  r_gp;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;

    logic [WIDTH-1:0] w_a2;
    logic [NGRP:0]    w_gc;
    logic [WIDTH-1:0] w_sum2;
    logic [NGRP-1:0]  w_gg2;
    logic [NGRP-1:0]  w_gp2;
    logic             w_blk_g;
    logic             w_ovf2;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_g;
    logic             r_p_blk;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;

    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
        assign {w_gg1[k], w_gp1[k]} = grp_gp(a[k*GRP_W +: GRP_W], w_b_eff[k*GRP_W +: GRP_W]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_gg       <= '0;
            r_gp       <= '0;
            r_p        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_gg  <= w_gg1;
                r_gp  <= w_gp1;
                r_p   <= a ^ w_b_eff;
                r_b   <= w_b_eff;
                r_cin <= w_cin_eff;
            end
        end
    end

    // Operand A is recovered from the registered bit propagate and effective B.
    assign w_a2 = r_p ^ r_b;

    // Each group carry is an independent sum of products over the registered group g/p.
    always_comb begin
        logic v_c;
        logic v_t;
        w_gc    = '0;
        w_blk_g = 1'b0;
        for (int unsigned k = 0; k <= NGRP; k++) begin
            v_t = r_cin;
            for (int unsigned m = 0; m < k; m++) v_t = v_t & r_gp[m];
            v_c = v_t;
            for (int unsigned j = 0; j < k; j++) begin
                v_t = r_gg[j];
                for (int unsigned m = j + 1; m < k; m++) v_t = v_t & r_gp[m];
                v_c = v_c | v_t;
            end
            w_gc[k] = v_c;
        end
        for (int unsigned j = 0; j < NGRP; j++) begin
            v_t = w_gg2[j];
            for (int unsigned m = j + 1; m < NGRP; m++) v_t = v_t & w_gp2[m];
            w_blk_g = w_blk_g | v_t;
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
        cla_group u_grp (
            .i_a (w_a2[k*GRP_W +: GRP_W]),
            .i_b (r_b[k*GRP_W +: GRP_W]),
            .i_c (w_gc[k]),
            .o_s (w_sum2[k*GRP_W +: GRP_W]),
            .o_g (w_gg2[k]),
            .o_p (w_gp2[k])
        );
    end

    // Carry into the MSB equals p ^ s at that bit.
    assign w_ovf2 = r_p[WIDTH-1] ^ w_sum2[WIDTH-1] ^ w_gc[NGRP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_g         <= 1'b0;
            r_p_blk     <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum   <= w_sum2;
                r_cout  <= w_gc[NGRP];
                r_ovf   <= w_ovf2;
                r_g     <= w_blk_g;
                r_p_blk <= &w_gp2;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign G         = r_g;
    assign P         = r_p_blk;

endmodule

// File: tb/tb_sum_cla_pipe.sv
// Bench for sum_cla_pipe (WIDTH=16): directed vectors with literal expectations plus an
// arithmetic reference model checked on every consumed or stalled result.
module tb_sum_cla_pipe;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         g;
        logic         p;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         G;
    logic         P;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t q[$];
    logic last_acc = 1'b0;
    logic hold_pend = 1'b0;
    res_t hold_val;

    always #5 clk = ~clk;

    sum_cla_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .G         (G),
        .P         (P)
    );

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        res_t         r;
        logic [W-1:0] ye;
        logic [W:0]   full;
        logic [W:0]   raw;
        ye     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, ye} + (s ? (W+1)'(1) : (W+1)'(c));
        raw    = {1'b0, x} + {1'b0, ye};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
        r.g    = raw[W];
        r.p    = &(x ^ ye);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic eg, input logic ep);
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        chk({name, "_ovf"}, 64'(ovf), 64'(eo));
        chk({name, "_G"}, 64'(G), 64'(eg));
        chk({name, "_P"}, 64'(P), 64'(ep));
    endtask

    // Scoreboard: push at acceptance, pop at consumption, hold check while stalled.
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        last_acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            cur = '{sum: sum, cout: cout, ovf: ovf, g: G, p: P};
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(cur), 64'(hold_val));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
                end else begin
                    exp = q.pop_front();
                    chk("model_result", 64'(cur), 64'(exp));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = cur;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                last_acc = 1'b1;
            end
        end
    end

    task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input logic [W-1:0] es, input logic ec,
                         input logic eo, input logic eg, input logic ep);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk) chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({name, "_lat2"}, 64'(out_valid), 64'd1);
        chk_out(name, es, ec, eo, eg, ep);
        @(posedge clk) #1;
    endtask

    initial begin
        res_t m;
        int   sent;
        int   cyc;

        // Model pins against hand arithmetic.
        m = model(16'h0007, 16'h0009, 1'b0, 1'b1);
        chk("pin_sub", 64'(m), 64'({16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0}));
        m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("pin_ovf", 64'(m), 64'({16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}));

        // Reset with in_valid asserted must not accept anything.
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk) #1;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk) chk("rst_ignore_valid", 64'(out_valid), 64'd0);
        @(posedge clk) #1;

        do_op("add_c_3",   16'h000C, 16'h0003, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("ffff_p1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_op("ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("sub_7_9",   16'h0007, 16'h0009, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("ovf_7fff",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("sub_5_5c",  16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: two beats fill the pipe, the third waits for the consumer.
        out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
        a = 16'h0010; b = 16'h0001;
        @(negedge clk) chk("bp_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk) #1 a = 16'h0020; b = 16'h0002;
        @(negedge clk) chk("bp_rdy2", 64'(in_ready), 64'd1);
        @(posedge clk) #1 a = 16'h0030; b = 16'h0003;
        @(negedge clk);
        chk("bp_rdy3", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_first", 64'(sum), 64'h0011);
        @(posedge clk) #1;
        @(negedge clk) chk("bp_still_full", 64'(in_ready), 64'd0);
        @(posedge clk) #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_rdy", 64'(in_ready), 64'd1);
        chk("bp_drain1", 64'(sum), 64'h0011);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) chk("bp_drain2", 64'(sum), 64'h0022);
        @(negedge clk) chk("bp_drain3", 64'(sum), 64'h0033);
        @(negedge clk) chk("bp_empty", 64'(q.size()), 64'd0);
        @(posedge clk) #1;

        // Mid-flight reset drops both operations in the pipe.
        in_valid = 1'b1; a = 16'h0100; b = 16'h0001;
        @(posedge clk) #1 a = 16'h0200; b = 16'h0002;
        @(posedge clk) #1 in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_sum", 64'(sum), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(negedge clk) chk("mrst_no_stale", 64'(out_valid), 64'd0);
        @(posedge clk) #1;

        // Random back-to-back traffic with random backpressure.
        sent = 0;
        cyc  = 0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk) #1;
            cyc++;
            if (last_acc) begin
                sent++;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
                if ($urandom_range(0, 7) == 0) b = 16'h8000;
            end
        end
        in_valid = 1'b0;
        chk("random_accepted", 64'(sent), 64'd1000);
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || out_valid) && cyc < 50) begin
            @(posedge clk) #1;
            cyc++;
        end
        chk("random_drained", 64'(q.size()), 64'd0);
        chk("random_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
